// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: commits traps into the M-mode CSRs, handles mret and
// redirects fetch, and serves the CSR read/write port for the registers it owns.
module trap_ctrl #(
    parameter int unsigned      XLEN        = 32,
    parameter int unsigned      MXLEN       = 32,
    parameter int unsigned      CAUSE_W     = 5,
    parameter logic [MXLEN-1:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic [XLEN-1:0]    i_pc,
    input  logic               i_trap_req,
    input  logic [CAUSE_W-1:0] i_trap_cause,
    input  logic [MXLEN-1:0]   i_trap_tval,
    input  logic               i_mret,
    input  logic               i_csr_we,
    input  logic [11:0]        i_csr_addr,
    input  logic [MXLEN-1:0]   i_csr_wdata,
    output logic [MXLEN-1:0]   o_csr_rdata,
    output logic               o_csr_hit,
    output logic               o_redirect,
    output logic [XLEN-1:0]    o_redirect_pc,
    output logic               o_busy
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;

    typedef enum logic [1:0] {StIdle, StTrap, StMret} state_e;

    state_e           state_q, state_d;
    logic [MXLEN-1:0] mtvec_q, mepc_q, mcause_q, mtval_q, mscratch_q;
    logic             mie_q, mpie_q;
    logic [XLEN-1:0]  target_q;

    logic take_trap, take_mret, csr_wr;

    // Commit-stage inputs only matter in IDLE; trap > mret > CSR write.
    assign take_trap = (state_q == StIdle) & i_valid & i_trap_req;
    assign take_mret = (state_q == StIdle) & i_valid & i_mret & ~i_trap_req;
    assign csr_wr    = (state_q == StIdle) & i_valid & i_csr_we & ~i_trap_req & ~i_mret;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (take_trap) begin
                    state_d = StTrap;
                end else if (take_mret) begin
                    state_d = StMret;
                end
            end
            StTrap:  state_d = StIdle;
            StMret:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_redirect = 1'b0;
        o_busy     = 1'b0;
        unique case (state_q)
            StTrap, StMret: begin
                o_redirect = 1'b1;
                o_busy     = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_redirect_pc = target_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mtvec_q    <= {RESET_MTVEC[MXLEN-1:2], 2'b00};
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mscratch_q <= '0;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            target_q   <= '0;
        end else if (take_trap) begin
            mepc_q   <= {i_pc[XLEN-1:2], 2'b00};
            mcause_q <= {{(MXLEN-CAUSE_W){1'b0}}, i_trap_cause};
            mtval_q  <= i_trap_tval;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
            target_q <= mtvec_q;
        end else if (take_mret) begin
            mie_q    <= mpie_q;
            mpie_q   <= 1'b1;
            target_q <= mepc_q;
        end else if (csr_wr) begin
            case (i_csr_addr)
                ADDR_MSTATUS: begin
                    mie_q  <= i_csr_wdata[3];
                    mpie_q <= i_csr_wdata[7];
                end
                ADDR_MTVEC:    mtvec_q    <= {i_csr_wdata[MXLEN-1:2], 2'b00};
                ADDR_MSCRATCH: mscratch_q <= i_csr_wdata;
                ADDR_MEPC:     mepc_q     <= {i_csr_wdata[MXLEN-1:2], 2'b00};
                ADDR_MCAUSE:   mcause_q   <= {1'b0, i_csr_wdata[MXLEN-2:0]};
                ADDR_MTVAL:    mtval_q    <= i_csr_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        o_csr_rdata = '0;
        o_csr_hit   = 1'b1;
        case (i_csr_addr)
            ADDR_MSTATUS: begin
                o_csr_rdata[12:11] = 2'b11;  // MPP hardwired to M-mode
                o_csr_rdata[7]     = mpie_q;
                o_csr_rdata[3]     = mie_q;
            end
            ADDR_MTVEC:    o_csr_rdata = mtvec_q;
            ADDR_MSCRATCH: o_csr_rdata = mscratch_q;
            ADDR_MEPC:     o_csr_rdata = mepc_q;
            ADDR_MCAUSE:   o_csr_rdata = mcause_q;
            ADDR_MTVAL:    o_csr_rdata = mtval_q;
            default:       o_csr_hit   = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed test-plan cases with literal expectations, then
// randomized commit traffic checked every cycle against a behavioural CSR model.
module tb_trap_ctrl;

    localparam logic [31:0] RST_TVEC = 32'h0000_1003;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid, i_trap_req, i_mret, i_csr_we;
    logic [31:0] i_pc, i_trap_tval, i_csr_wdata;
    logic [4:0]  i_trap_cause;
    logic [11:0] i_csr_addr;
    logic [31:0] o_csr_rdata, o_redirect_pc;
    logic        o_csr_hit, o_redirect, o_busy;

    trap_ctrl #(
        .XLEN       (32),
        .MXLEN      (32),
        .CAUSE_W    (5),
        .RESET_MTVEC(RST_TVEC)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (i_valid),
        .i_pc         (i_pc),
        .i_trap_req   (i_trap_req),
        .i_trap_cause (i_trap_cause),
        .i_trap_tval  (i_trap_tval),
        .i_mret       (i_mret),
        .i_csr_we     (i_csr_we),
        .i_csr_addr   (i_csr_addr),
        .i_csr_wdata  (i_csr_wdata),
        .o_csr_rdata  (o_csr_rdata),
        .o_csr_hit    (o_csr_hit),
        .o_redirect   (o_redirect),
        .o_redirect_pc(o_redirect_pc),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit check_en = 0;

    // Behavioural model: architectural CSR values plus the pending redirect.
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch, m_pc;
    logic        m_mie, m_mpie, m_redir;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_mtvec    = RST_TVEC & ~32'h3;
        m_mepc     = '0;
        m_mcause   = '0;
        m_mtval    = '0;
        m_mscratch = '0;
        m_mie      = 1'b0;
        m_mpie     = 1'b0;
        m_redir    = 1'b0;
        m_pc       = '0;
    endtask

    task automatic model_step();
        if (m_redir) begin
            m_redir = 1'b0;  // redirect cycle: commit inputs are ignored
        end else if (i_valid && i_trap_req) begin
            m_pc     = m_mtvec;
            m_mepc   = i_pc & ~32'h3;
            m_mcause = 32'(i_trap_cause);
            m_mtval  = i_trap_tval;
            m_mpie   = m_mie;
            m_mie    = 1'b0;
            m_redir  = 1'b1;
        end else if (i_valid && i_mret) begin
            m_pc    = m_mepc;
            m_mie   = m_mpie;
            m_mpie  = 1'b1;
            m_redir = 1'b1;
        end else if (i_valid && i_csr_we) begin
            case (i_csr_addr)
                12'h300: begin m_mie = i_csr_wdata[3]; m_mpie = i_csr_wdata[7]; end
                12'h305: m_mtvec    = i_csr_wdata & ~32'h3;
                12'h340: m_mscratch = i_csr_wdata;
                12'h341: m_mepc     = i_csr_wdata & ~32'h3;
                12'h342: m_mcause   = i_csr_wdata & 32'h7fff_ffff;
                12'h343: m_mtval    = i_csr_wdata;
                default: ;
            endcase
        end
    endtask

    function automatic logic [32:0] exp_read(input logic [11:0] addr);
        case (addr)
            12'h300: return {1'b1, 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3)};
            12'h305: return {1'b1, m_mtvec};
            12'h340: return {1'b1, m_mscratch};
            12'h341: return {1'b1, m_mepc};
            12'h342: return {1'b1, m_mcause};
            12'h343: return {1'b1, m_mtval};
            default: return 33'h0;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) reset_model();
            else model_step();
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (check_en) begin
                e = exp_read(i_csr_addr);
                chk("redirect", 32'(o_redirect), 32'(m_redir));
                chk("busy", 32'(o_busy), 32'(m_redir));
                chk("redirect_pc", o_redirect_pc, m_pc);
                chk("csr_hit", 32'(o_csr_hit), 32'(e[32]));
                chk("csr_rdata", o_csr_rdata, e[31:0]);
            end
        end
    end

    task automatic idle_inputs();
        i_valid = 0; i_trap_req = 0; i_mret = 0; i_csr_we = 0;
        i_pc = '0; i_trap_cause = '0; i_trap_tval = '0;
        i_csr_addr = 12'h7c0; i_csr_wdata = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
        i_csr_addr = addr;
        #1;
        chk(name, o_csr_rdata, exp);
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        idle_inputs();
        i_valid = 1; i_csr_we = 1; i_csr_addr = addr; i_csr_wdata = data;
        cycle();
        idle_inputs();
    endtask

    logic [11:0] addrs [7] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h7c0};

    initial begin
        reset_model();
        idle_inputs();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        check_en = 1;

        // Reset values
        chk("reset_redirect", 32'(o_redirect), 32'h0);
        rd("reset_mstatus", 12'h300, 32'h0000_1800);
        rd("reset_mtvec", 12'h305, 32'h0000_1000);
        rd("reset_mepc", 12'h341, 32'h0);
        rd("reset_mcause", 12'h342, 32'h0);
        rd("reset_mtval", 12'h343, 32'h0);
        rd("reset_mscratch", 12'h340, 32'h0);
        i_csr_addr = 12'h7c0;
        #1;
        chk("unmapped_hit", 32'(o_csr_hit), 32'h0);

        // Program mtvec and MIE, then trap
        csr_write(12'h305, 32'h8000_0103);
        csr_write(12'h300, 32'h0000_0008);
        rd("mtvec_masked", 12'h305, 32'h8000_0100);
        i_valid = 1; i_trap_req = 1; i_pc = 32'h0000_2006; i_trap_cause = 5'd2;
        i_trap_tval = 32'hdead_beef;
        cycle();
        idle_inputs();
        chk("trap_redirect", 32'(o_redirect), 32'h1);
        chk("trap_busy", 32'(o_busy), 32'h1);
        chk("trap_pc", o_redirect_pc, 32'h8000_0100);
        cycle();
        chk("trap_pulse_end", 32'(o_redirect), 32'h0);
        rd("trap_mepc", 12'h341, 32'h0000_2004);
        rd("trap_mcause", 12'h342, 32'h2);
        rd("trap_mtval", 12'h343, 32'hdead_beef);
        rd("trap_mstatus", 12'h300, 32'h0000_1880);

        // mret
        i_valid = 1; i_mret = 1;
        cycle();
        idle_inputs();
        chk("mret_redirect", 32'(o_redirect), 32'h1);
        chk("mret_pc", o_redirect_pc, 32'h0000_2004);
        cycle();
        rd("mret_mstatus", 12'h300, 32'h0000_1888);

        // Trap + mret + CSR write in one cycle; a second trap during TRAP is ignored
        i_valid = 1; i_trap_req = 1; i_mret = 1; i_csr_we = 1;
        i_csr_addr = 12'h340; i_csr_wdata = 32'h55; i_pc = 32'h0000_0100; i_trap_cause = 5'd7;
        cycle();
        i_mret = 0; i_csr_we = 0; i_pc = 32'h0000_3000;
        chk("prio_pc", o_redirect_pc, 32'h8000_0100);
        cycle();
        idle_inputs();
        chk("ignored_trap_redirect", 32'(o_redirect), 32'h0);
        rd("prio_mscratch", 12'h340, 32'h0);
        rd("ignored_trap_mepc", 12'h341, 32'h0000_0100);

        // Trap request without valid
        i_trap_req = 1; i_pc = 32'h0000_5000;
        cycle();
        idle_inputs();
        chk("novalid_redirect", 32'(o_redirect), 32'h0);
        rd("novalid_mepc", 12'h341, 32'h0000_0100);

        // Reset during the TRAP cycle
        i_valid = 1; i_trap_req = 1; i_pc = 32'h0000_4000; i_trap_cause = 5'd5;
        cycle();
        idle_inputs();
        chk("pre_rst_redirect", 32'(o_redirect), 32'h1);
        rst = 1;
        #1;
        chk("rst_redirect", 32'(o_redirect), 32'h0);
        chk("rst_busy", 32'(o_busy), 32'h0);
        rd("rst_mepc", 12'h341, 32'h0);
        rd("rst_mtvec", 12'h305, 32'h0000_1000);
        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        rst = 0;
        cycle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            i_valid      = ($urandom_range(3) != 0);
            i_trap_req   = ($urandom_range(5) == 0);
            i_mret       = ($urandom_range(5) == 0);
            i_csr_we     = ($urandom_range(2) == 0);
            i_csr_addr   = ($urandom_range(7) == 7) ? 12'($urandom) : addrs[$urandom_range(6)];
            i_csr_wdata  = $urandom;
            i_pc         = $urandom;
            i_trap_cause = 5'($urandom);
            i_trap_tval  = $urandom;
            if ($urandom_range(399) == 0) begin
                rst = 1;
                cycle();
                rst = 0;
            end else begin
                cycle();
            end
        end

        idle_inputs();
        cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
